// File: rtl/seq_loss_tracker.sv
// rtl/seq_loss_tracker.sv - per-channel sequence loss/duplicate tracker over a bitmap RAM
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   start       re-arm pulse, honoured only in DONE
//   valid_in    frame descriptor strobe
//   ch_in       arrival channel (values >= NUM_CH are ignored)
//   seq_in      frame sequence number
//   end_in      last frame of the run (qualified by valid_in)
//   rx_cnt      per-channel distinct-seq counts, channel c at [c*CNT_W +: CNT_W]
//   ok_cnt      seqs seen on at least one channel
//   lost_cnt    seqs in 0..max_seq seen on no channel
//   dup_cnt     arrivals whose (ch,seq) bit was already set
//   total_cnt   seqs scanned
//   max_seq     highest seq recorded this run
//   busy        high in CLEAR, DRAIN and SCAN
//   done        high in DONE; counters final

module seq_loss_tracker #(
  parameter int SEQ_BITS = 12,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DEPTH   = 1 << SEQ_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      valid_in,
  input  logic [CH_W-1:0]           ch_in,
  input  logic [SEQ_BITS-1:0]       seq_in,
  input  logic                      end_in,
  output logic [NUM_CH*CNT_W-1:0]   rx_cnt,
  output logic [CNT_W-1:0]          ok_cnt,
  output logic [CNT_W-1:0]          lost_cnt,
  output logic [CNT_W-1:0]          dup_cnt,
  output logic [CNT_W-1:0]          total_cnt,
  output logic [SEQ_BITS-1:0]       max_seq,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_WAIT,
    S_RUN,
    S_DRAIN,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [CH_W:0] NUM_CH_V = NUM_CH[CH_W:0];

  state_t state, state_n;

  logic [NUM_CH-1:0]   mem [DEPTH];
  logic [NUM_CH-1:0]   rd_q;
  logic                we;
  logic [SEQ_BITS-1:0] wa;
  logic [NUM_CH-1:0]   wd;
  logic [SEQ_BITS-1:0] ra;

  logic [SEQ_BITS-1:0] idx;
  logic                drain_cnt;
  logic                scan_rd_done;

  // stage 1 of the arrival pipe: read issued, word arrives in rd_q
  logic                p_valid;
  logic [SEQ_BITS-1:0] p_seq;
  logic [CH_W-1:0]     p_ch;

  // word written by stage 2 on the previous edge; the RAM read issued on
  // that same edge returned the stale value, so it is patched from here
  logic                fwd_valid;
  logic [SEQ_BITS-1:0] fwd_seq;
  logic [NUM_CH-1:0]   fwd_word;

  // scan pipe: address read last cycle, evaluated and zeroed this cycle
  logic                sv_valid;
  logic [SEQ_BITS-1:0] sv_addr;

  logic                legal;
  logic                accept;
  logic [NUM_CH-1:0]   base_word;
  logic [NUM_CH-1:0]   p_bit;
  logic [NUM_CH-1:0]   new_word;
  logic                is_dup;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    legal     = valid_in && ({1'b0, ch_in} < NUM_CH_V);
    accept    = legal && ((state == S_WAIT && seq_in == '0) || state == S_RUN);
    base_word = (fwd_valid && fwd_seq == p_seq) ? fwd_word : rd_q;
    p_bit     = NUM_CH'(1) << p_ch;
    is_dup    = |(base_word & p_bit);
    new_word  = base_word | p_bit;
  end

  always_comb begin
    we = 1'b0;
    wa = idx;
    wd = '0;
    if (state == S_CLEAR) begin
      we = 1'b1;
    end else if (p_valid && !is_dup) begin
      we = 1'b1;
      wa = p_seq;
      wd = new_word;
    end else if (sv_valid) begin
      we = 1'b1;
      wa = sv_addr;
    end
    ra = (state == S_SCAN) ? idx : seq_in;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[ra];
  end

  always_comb begin
    state_n = state;
    case (state)
      S_CLEAR: if (idx == '1) state_n = S_WAIT;
      S_WAIT:  if (accept) state_n = end_in ? S_DRAIN : S_RUN;
      S_RUN:   if (accept && end_in) state_n = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_n = S_SCAN;
      S_SCAN:  if (sv_valid && sv_addr == max_seq) state_n = S_DONE;
      S_DONE:  if (start) state_n = S_WAIT;
      default: state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLEAR;
      idx          <= '0;
      drain_cnt    <= 1'b0;
      scan_rd_done <= 1'b0;
      p_valid      <= 1'b0;
      p_seq        <= '0;
      p_ch         <= '0;
      fwd_valid    <= 1'b0;
      fwd_seq      <= '0;
      fwd_word     <= '0;
      sv_valid     <= 1'b0;
      sv_addr      <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      p_valid   <= accept;
      p_seq     <= seq_in;
      p_ch      <= ch_in;
      fwd_valid <= p_valid;
      fwd_seq   <= p_seq;
      fwd_word  <= new_word;
      sv_valid  <= (state == S_SCAN) && !scan_rd_done;
      sv_addr   <= idx;
      case (state)
        S_CLEAR: idx <= idx + 1'b1;
        S_DRAIN: begin
          idx          <= '0;
          scan_rd_done <= 1'b0;
        end
        S_SCAN: begin
          if (!scan_rd_done) begin
            if (idx == max_seq) scan_rd_done <= 1'b1;
            else                idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state == S_DONE && start)) begin
      rx_cnt    <= '0;
      ok_cnt    <= '0;
      lost_cnt  <= '0;
      dup_cnt   <= '0;
      total_cnt <= '0;
      max_seq   <= '0;
    end else begin
      if (accept && seq_in > max_seq) max_seq <= seq_in;
      if (p_valid && is_dup) dup_cnt <= sat_inc(dup_cnt);
      if (sv_valid) begin
        total_cnt <= sat_inc(total_cnt);
        if (rd_q != '0) ok_cnt   <= sat_inc(ok_cnt);
        else            lost_cnt <= sat_inc(lost_cnt);
        for (int c = 0; c < NUM_CH; c++) begin
          if (rd_q[c]) rx_cnt[c*CNT_W +: CNT_W] <= sat_inc(rx_cnt[c*CNT_W +: CNT_W]);
        end
      end
    end
  end

  // status flags registered from the next state so reset drives them low
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n == S_CLEAR) || (state_n == S_DRAIN) || (state_n == S_SCAN);
      done <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_seq_loss_tracker.sv
// tb/tb_seq_loss_tracker.sv - self-checking bench for seq_loss_tracker

module tb_seq_loss_tracker;

  localparam int DA = 4096;
  localparam int DB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, valid_a, end_a;
  logic [0:0]  ch_a;
  logic [11:0] seq_a;
  logic [31:0] rx_a;
  logic [15:0] ok_a, lost_a, dup_a, total_a;
  logic [11:0] max_a;
  logic        busy_a, done_a;

  logic        rst_b, start_b, valid_b, end_b;
  logic [1:0]  ch_b;
  logic [5:0]  seq_b;
  logic [11:0] rx_b;
  logic [3:0]  ok_b, lost_b, dup_b, total_b;
  logic [5:0]  max_b;
  logic        busy_b, done_b;

  seq_loss_tracker dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .valid_in(valid_a), .ch_in(ch_a),
    .seq_in(seq_a), .end_in(end_a), .rx_cnt(rx_a), .ok_cnt(ok_a), .lost_cnt(lost_a),
    .dup_cnt(dup_a), .total_cnt(total_a), .max_seq(max_a), .busy(busy_a), .done(done_a)
  );

  seq_loss_tracker #(.SEQ_BITS(6), .NUM_CH(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .valid_in(valid_b), .ch_in(ch_b),
    .seq_in(seq_b), .end_in(end_b), .rx_cnt(rx_b), .ok_cnt(ok_b), .lost_cnt(lost_b),
    .dup_cnt(dup_b), .total_cnt(total_b), .max_seq(max_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  int cur = 0;

  int o_ok, o_lost, o_dup, o_total, o_max, o_busy, o_done;
  int o_rx [3];

  always_comb begin
    o_ok = 0; o_lost = 0; o_dup = 0; o_total = 0; o_max = 0; o_busy = 0; o_done = 0;
    for (int c = 0; c < 3; c++) o_rx[c] = 0;
    if (cur == 0) begin
      o_ok = int'(ok_a); o_lost = int'(lost_a); o_dup = int'(dup_a); o_total = int'(total_a);
      o_max = int'(max_a); o_busy = int'(busy_a); o_done = int'(done_a);
      for (int c = 0; c < 2; c++) o_rx[c] = int'(rx_a[c*16 +: 16]);
    end else begin
      o_ok = int'(ok_b); o_lost = int'(lost_b); o_dup = int'(dup_b); o_total = int'(total_b);
      o_max = int'(max_b); o_busy = int'(busy_b); o_done = int'(done_b);
      for (int c = 0; c < 3; c++) o_rx[c] = int'(rx_b[c*4 +: 4]);
    end
  end

  // reference model: set of (ch,seq) bits recorded this run plus run phase
  bit mbits [3][4096];
  int mphase, mdup, mmax, mnch, mcap;
  int e_ok, e_lost, e_dup, e_total, e_max;
  int e_rx [3];

  function automatic void model_reset(input int d);
    for (int c = 0; c < 3; c++)
      for (int s = 0; s < 4096; s++) mbits[c][s] = 1'b0;
    mphase = 0; mdup = 0; mmax = 0;
    mnch = (d == 0) ? 2 : 3;
    mcap = (d == 0) ? 65535 : 15;
  endfunction

  function automatic void model_arrive(input int ch, input int seq, input bit e);
    if (ch >= mnch || mphase == 2) return;
    if (mphase == 0 && seq != 0) return;
    if (mbits[ch][seq]) mdup++;
    else mbits[ch][seq] = 1'b1;
    if (seq > mmax) mmax = seq;
    mphase = e ? 2 : 1;
  endfunction

  function automatic int sat(input int v);
    return (v > mcap) ? mcap : v;
  endfunction

  function automatic void model_expect();
    int ok;
    int lost;
    bit any;
    int rx [3];
    ok = 0; lost = 0;
    for (int c = 0; c < 3; c++) rx[c] = 0;
    for (int s = 0; s <= mmax; s++) begin
      any = 1'b0;
      for (int c = 0; c < mnch; c++) if (mbits[c][s]) begin any = 1'b1; rx[c]++; end
      if (any) ok++; else lost++;
    end
    e_ok = sat(ok); e_lost = sat(lost); e_dup = sat(mdup);
    e_total = sat(mmax + 1); e_max = mmax;
    for (int c = 0; c < 3; c++) e_rx[c] = sat(rx[c]);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input int d, input int ch, input int seq, input bit e, input int gap);
    repeat (gap) cyc();
    if (d == 0) begin
      valid_a = 1'b1; ch_a = 1'(ch); seq_a = 12'(seq); end_a = e;
    end else begin
      valid_b = 1'b1; ch_b = 2'(ch); seq_b = 6'(seq); end_b = e;
    end
    model_arrive(ch, seq, e);
    cyc();
    valid_a = 1'b0; end_a = 1'b0; valid_b = 1'b0; end_b = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (o_done == 0 && n < 10000) begin
      cyc();
      n++;
    end
    checks++;
    if (o_done == 0) begin
      errors++;
      $display("FAIL %s done_timeout got done=%0d exp 1 within 10000 cycles", tag, o_done);
    end
  endtask

  task automatic do_start(input int d);
    if (d == 0) start_a = 1'b1; else start_b = 1'b1;
    cyc();
    start_a = 1'b0; start_b = 1'b0;
    model_reset(d);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    cyc(); cyc();
    for (int d = 0; d < 2; d++) begin
      cur = d; #1;
      checks++;
      if ({o_ok, o_lost, o_dup, o_total, o_max, o_busy, o_done, o_rx[0], o_rx[1]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got ok=%0d lost=%0d dup=%0d total=%0d max=%0d busy=%0d done=%0d exp all 0",
                 d, o_ok, o_lost, o_dup, o_total, o_max, o_busy, o_done);
      end
    end
    cur = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (DA - 1) cyc();
    checks++;
    if (o_busy !== 1) begin errors++; $display("FAIL clear_busy got %0d exp 1", o_busy); end
    cyc();
    checks++;
    if (o_busy !== 0 || o_done !== 0) begin
      errors++; $display("FAIL clear_end got busy=%0d done=%0d exp 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_basic();
    cur = 0; model_reset(0);
    for (int s = 0; s < 100; s++) send(0, 0, s, s == 99, 0);
    wait_done("basic");
    checks++;
    if (o_ok !== 100 || o_lost !== 0 || o_dup !== 0 || o_total !== 100) begin
      errors++; $display("FAIL basic_totals got ok=%0d lost=%0d dup=%0d total=%0d exp 100 0 0 100", o_ok, o_lost, o_dup, o_total);
    end
    checks++;
    if (o_rx[0] !== 100 || o_rx[1] !== 0 || o_max !== 99) begin
      errors++; $display("FAIL basic_rx got rx0=%0d rx1=%0d max=%0d exp 100 0 99", o_rx[0], o_rx[1], o_max);
    end
    do_start(0);
  endtask

  task automatic test_gaps();
    cur = 0;
    for (int s = 0; s < 10; s++) begin
      if (s != 3 && s != 7) send(0, 0, s, s == 9, 0);
      if (s == 5) send(0, 1, 5, 1'b0, 1);
    end
    wait_done("gaps");
    checks++;
    if (o_ok !== 8 || o_lost !== 2 || o_total !== 10 || o_dup !== 0) begin
      errors++; $display("FAIL gaps_totals got ok=%0d lost=%0d total=%0d dup=%0d exp 8 2 10 0", o_ok, o_lost, o_total, o_dup);
    end
    checks++;
    if (o_rx[0] !== 8 || o_rx[1] !== 1) begin
      errors++; $display("FAIL gaps_rx got rx0=%0d rx1=%0d exp 8 1", o_rx[0], o_rx[1]);
    end
    do_start(0);
  endtask

  task automatic test_back_to_back();
    cur = 0;
    send(0, 0, 0, 1'b0, 0);
    send(0, 1, 4, 1'b0, 0);
    send(0, 1, 4, 1'b0, 0);
    send(0, 1, 4, 1'b0, 1);
    send(0, 0, 4, 1'b0, 0);
    send(0, 1, 6, 1'b0, 0);
    send(0, 1, 8, 1'b0, 0);
    send(0, 1, 6, 1'b0, 0);
    send(0, 0, 5, 1'b1, 0);
    wait_done("b2b");
    checks++;
    if (o_dup !== 3) begin errors++; $display("FAIL b2b_dup got %0d exp 3", o_dup); end
    checks++;
    if (o_rx[0] !== 3 || o_rx[1] !== 3) begin
      errors++; $display("FAIL b2b_rx got rx0=%0d rx1=%0d exp 3 3", o_rx[0], o_rx[1]);
    end
    checks++;
    if (o_ok !== 5 || o_lost !== 4 || o_total !== 9 || o_max !== 8) begin
      errors++; $display("FAIL b2b_totals got ok=%0d lost=%0d total=%0d max=%0d exp 5 4 9 8", o_ok, o_lost, o_total, o_max);
    end
    do_start(0);
  endtask

  task automatic test_wait_ignore();
    cur = 0;
    send(0, 0, 5, 1'b0, 0);
    send(0, 1, 6, 1'b1, 0);
    checks++;
    if (o_max !== 0 || o_busy !== 0) begin
      errors++; $display("FAIL wait_ignore got max=%0d busy=%0d exp 0 0", o_max, o_busy);
    end
    for (int s = 0; s < 4; s++) send(0, 1, s, s == 3, 0);
    wait_done("wait1");
    checks++;
    if (o_total !== 4 || o_ok !== 4 || o_lost !== 0 || o_rx[1] !== 4) begin
      errors++; $display("FAIL wait_run1 got total=%0d ok=%0d lost=%0d rx1=%0d exp 4 4 0 4", o_total, o_ok, o_lost, o_rx[1]);
    end
    do_start(0);
    checks++;
    if (o_done !== 0 || o_ok !== 0 || o_total !== 0 || o_max !== 0) begin
      errors++; $display("FAIL start_clear got done=%0d ok=%0d total=%0d max=%0d exp 0 0 0 0", o_done, o_ok, o_total, o_max);
    end
    send(0, 0, 0, 1'b0, 0);
    send(0, 0, 1, 1'b1, 0);
    wait_done("wait2");
    checks++;
    if (o_total !== 2 || o_ok !== 2 || o_rx[1] !== 0) begin
      errors++; $display("FAIL wait_run2 got total=%0d ok=%0d rx1=%0d exp 2 2 0", o_total, o_ok, o_rx[1]);
    end
    do_start(0);
    send(0, 0, 0, 1'b0, 0);
    send(0, 0, 5, 1'b1, 0);
    wait_done("wait3");
    checks++;
    if (o_total !== 6 || o_ok !== 2 || o_lost !== 4 || o_rx[1] !== 0) begin
      errors++; $display("FAIL stale_bits got total=%0d ok=%0d lost=%0d rx1=%0d exp 6 2 4 0", o_total, o_ok, o_lost, o_rx[1]);
    end
    do_start(0);
  endtask

  task automatic test_reset_mid_scan();
    cur = 0;
    send(0, 0, 0, 1'b0, 0);
    send(0, 1, 4000, 1'b1, 0);
    repeat (20) cyc();
    checks++;
    if (o_busy !== 1 || o_done !== 0) begin
      errors++; $display("FAIL mid_scan_busy got busy=%0d done=%0d exp 1 0", o_busy, o_done);
    end
    rst_a = 1'b1;
    cyc();
    checks++;
    if ({o_ok, o_lost, o_total, o_max, o_busy, o_done, o_rx[0], o_rx[1]} !== '0) begin
      errors++; $display("FAIL mid_scan_rst got ok=%0d lost=%0d total=%0d max=%0d busy=%0d exp all 0", o_ok, o_lost, o_total, o_max, o_busy);
    end
    rst_a = 1'b0;
    repeat (DA - 1) cyc();
    checks++;
    if (o_busy !== 1) begin errors++; $display("FAIL reclear_busy got %0d exp 1", o_busy); end
    cyc();
    checks++;
    if (o_busy !== 0) begin errors++; $display("FAIL reclear_end got %0d exp 0", o_busy); end
    model_reset(0);
    send(0, 0, 0, 1'b0, 0);
    send(0, 0, 4000, 1'b1, 0);
    wait_done("post_rst");
    checks++;
    if (o_ok !== 2 || o_lost !== 3999 || o_total !== 4001 || o_rx[1] !== 0) begin
      errors++; $display("FAIL post_rst got ok=%0d lost=%0d total=%0d rx1=%0d exp 2 3999 4001 0", o_ok, o_lost, o_total, o_rx[1]);
    end
    do_start(0);
    cur = 1; model_reset(1);
    for (int s = 0; s < 20; s++) send(1, 0, s, s == 19, 0);
    wait_done("sat");
    checks++;
    if (o_ok !== 15 || o_total !== 15 || o_lost !== 0 || o_rx[0] !== 15 || o_max !== 19) begin
      errors++; $display("FAIL saturate got ok=%0d total=%0d lost=%0d rx0=%0d max=%0d exp 15 15 0 15 19", o_ok, o_total, o_lost, o_rx[0], o_max);
    end
    do_start(1);
  endtask

  task automatic test_illegal_ch();
    cur = 1;
    send(1, 0, 0, 1'b0, 0);
    send(1, 2, 10, 1'b0, 0);
    send(1, 3, 50, 1'b1, 0);
    repeat (3) cyc();
    checks++;
    if (o_max !== 10 || o_busy !== 0 || o_done !== 0) begin
      errors++; $display("FAIL illegal_ch got max=%0d busy=%0d done=%0d exp 10 0 0", o_max, o_busy, o_done);
    end
    send(1, 1, 12, 1'b0, 0);
    send(1, 0, 13, 1'b1, 0);
    wait_done("illegal");
    checks++;
    if (o_max !== 13 || o_total !== 14 || o_ok !== 4 || o_lost !== 10) begin
      errors++; $display("FAIL illegal_totals got max=%0d total=%0d ok=%0d lost=%0d exp 13 14 4 10", o_max, o_total, o_ok, o_lost);
    end
    checks++;
    if (o_rx[0] !== 2 || o_rx[1] !== 1 || o_rx[2] !== 1 || o_dup !== 0) begin
      errors++; $display("FAIL illegal_rx got rx0=%0d rx1=%0d rx2=%0d dup=%0d exp 2 1 1 0", o_rx[0], o_rx[1], o_rx[2], o_dup);
    end
    do_start(1);
  endtask

  task automatic test_random();
    int d, nch_drv, lim, nfr, ch, seq;
    bit e;
    for (int r = 0; r < 12; r++) begin
      d = r % 2;
      cur = d;
      model_reset(d);
      nch_drv = (d == 0) ? 2 : 4;
      lim = (d == 0) ? $urandom_range(5, 300) : $urandom_range(3, 63);
      nfr = $urandom_range(10, 60);
      repeat ($urandom_range(0, 3)) send(d, $urandom_range(0, nch_drv - 1), $urandom_range(1, lim), $urandom_range(0, 1), $urandom_range(0, 2));
      send(d, $urandom_range(0, mnch - 1), 0, 1'b0, $urandom_range(0, 2));
      for (int i = 0; i < nfr; i++) begin
        ch = $urandom_range(0, nch_drv - 1);
        seq = ($urandom_range(0, 3) == 0) ? seq : $urandom_range(0, lim);
        e = (ch >= mnch) ? 1'($urandom_range(0, 1)) : 1'b0;
        send(d, ch, seq, e, $urandom_range(0, 2));
      end
      send(d, $urandom_range(0, mnch - 1), $urandom_range(0, lim), 1'b1, $urandom_range(0, 2));
      wait_done("random");
      model_expect();
      checks++;
      if (o_ok !== e_ok || o_lost !== e_lost || o_dup !== e_dup || o_total !== e_total || o_max !== e_max) begin
        errors++;
        $display("FAIL random_run%0d got ok=%0d lost=%0d dup=%0d total=%0d max=%0d exp %0d %0d %0d %0d %0d",
                 r, o_ok, o_lost, o_dup, o_total, o_max, e_ok, e_lost, e_dup, e_total, e_max);
      end
      for (int c = 0; c < mnch; c++) begin
        checks++;
        if (o_rx[c] !== e_rx[c]) begin
          errors++; $display("FAIL random_run%0d rx%0d got %0d exp %0d", r, c, o_rx[c], e_rx[c]);
        end
      end
      do_start(d);
    end
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; valid_a = 1'b0; end_a = 1'b0; ch_a = '0; seq_a = '0;
    rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; end_b = 1'b0; ch_b = '0; seq_b = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_wait_ignore();
    test_reset_mid_scan();
    test_illegal_ch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
